// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and active-low 7-segment encodings (ABCDEFG).
// Revision    : 1.0
// ============================================================================
package seg_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [1:7] seg_code_t;

    localparam seg_code_t SEG_BLANK = 7'b1111111;

    localparam seg_code_t SEG_0 = 7'b0000001;
    localparam seg_code_t SEG_1 = 7'b1001111;
    localparam seg_code_t SEG_2 = 7'b0010010;
    localparam seg_code_t SEG_3 = 7'b0000110;
    localparam seg_code_t SEG_4 = 7'b1001100;
    localparam seg_code_t SEG_5 = 7'b0100100;
    localparam seg_code_t SEG_6 = 7'b0100000;
    localparam seg_code_t SEG_7 = 7'b0001111;
    localparam seg_code_t SEG_8 = 7'b0000000;
    localparam seg_code_t SEG_9 = 7'b0000100;

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl_if
// Description : Digit source / display pin bundle for the scan controller.
// Revision    : 1.0
// ============================================================================
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    pending;
    logic                    applied;
    logic                    frame_tick;
    logic [1:7]              leds;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output digits_in, load,
        input  pending, applied, frame_tick, leds, an
    );

    modport slave (
        input  digits_in, load,
        output pending, applied, frame_tick, leds, an
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl_segment7.sv
`default_nettype none
// ============================================================================
// Module      : segment7
// Description : Combinational BCD to active-low 7-segment decoder.
// Revision    : 1.0
// ============================================================================
module segment7
    import seg_pkg::*;
(
    input  bcd_digit_t i_bcd,
    output seg_code_t  o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Multiplexed 7-segment scan controller with tear-free
//               double-buffered display value and leading-zero blanking.
// Revision    : 1.0
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int DEAD       = 2,
    parameter int BLANK_LZ   = 1
) (
    input  logic            clk,
    input  logic            reset,
    seg_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_staging;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic                    r_pending;
    logic                    r_applied;
    logic                    r_frame_tick;
    logic [NUM_DIGITS-1:0]   r_an;
    seg_code_t               r_leds;

    logic                    w_cnt_tc;
    logic                    w_idx_last;
    logic                    w_wrap;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    bcd_digit_t              w_disp_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    bcd_digit_t              w_cur_digit;
    seg_code_t               w_seg_dec;
    logic                    w_invalid;
    logic                    w_lz_blank;

    assign w_cnt_tc   = (r_cnt == CNT_W'(PRESCALE - 1));
    assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_wrap     = w_cnt_tc && w_idx_last;
    assign w_cnt_nxt  = w_cnt_tc ? '0 : r_cnt + CNT_W'(1);

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_cnt_tc) begin
            w_idx_nxt = w_idx_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    // w_upper_zero[k]: display digits k..NUM_DIGITS-1 are all zero
    always_comb begin
        logic v_run;
        v_run        = 1'b1;
        w_upper_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_disp_arr[k]   = r_display[4*k +: 4];
            v_run           = v_run && (w_disp_arr[k] == 4'd0);
            w_upper_zero[k] = v_run;
        end
    end

    assign w_cur_digit = w_disp_arr[r_idx];
    assign w_invalid   = (w_cur_digit > 4'd9);
    assign w_lz_blank  = (BLANK_LZ != 0) && (r_idx != '0) && w_upper_zero[r_idx];

    segment7 u_segment7 (
        .i_bcd (w_cur_digit),
        .o_seg (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_staging    <= '0;
            r_display    <= '0;
            r_pending    <= 1'b0;
            r_applied    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_an         <= '1;
            r_leds       <= SEG_BLANK;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_frame_tick <= w_wrap;
            r_applied    <= w_wrap && r_pending;

            // Commit uses the pre-edge staging, so a load on the wrap cycle waits a frame
            if (w_wrap && r_pending) begin
                r_display <= r_staging;
            end

            if (bus.load) begin
                r_staging <= bus.digits_in;
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end

            // Anodes track the next count so they line up with r_cnt
            if (w_cnt_nxt < CNT_W'(DEAD)) begin
                r_an <= '1;
            end else begin
                r_an <= ~(NUM_DIGITS'(1) << w_idx_nxt);
            end

            // One cycle behind the slot; hidden by the dead time (DEAD >= 1)
            r_leds <= (w_invalid || w_lz_blank) ? SEG_BLANK : w_seg_dec;
        end
    end

    assign bus.pending    = r_pending;
    assign bus.applied    = r_applied;
    assign bus.frame_tick = r_frame_tick;
    assign bus.an         = r_an;
    assign bus.leds       = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed scoreboard bench for seg_scan_ctrl (LZ on and off).
// Revision    : 1.0
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int P = 8;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld;
    logic [15:0] din;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus1 ();
    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus0 ();

    assign bus1.digits_in = din;
    assign bus1.load      = ld;
    assign bus0.digits_in = din;
    assign bus0.load      = ld;

    seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD(D), .BLANK_LZ(1)) u_dut_lz (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD(D), .BLANK_LZ(0)) u_dut_nolz (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    // Reference model state; sb_q holds the value awaiting commit
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_disp = '0;
    logic        m_app = 1'b0;
    logic        m_ft = 1'b0;
    logic [15:0] sb_q [$];
    int          n_app = 0;

    int errors = 0;
    int checks = 0;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_leds(input logic [15:0] disp, input int idx, input bit lz);
        logic [15:0] upper;
        upper = disp >> (4 * idx);
        if (lz && idx > 0 && upper == 16'h0) return 7'b1111111;
        return dec(upper[3:0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock, update the model from the sampled inputs, compare outputs
    task automatic step();
        bit         wrap;
        bit         was_reset;
        logic [3:0] ea;
        @(posedge clk);
        was_reset = reset;
        if (reset) begin
            m_cnt = 0; m_idx = 0; m_disp = '0; m_app = 1'b0; m_ft = 1'b0;
            sb_q.delete();
        end else begin
            wrap  = (m_cnt == P - 1) && (m_idx == N - 1);
            m_ft  = wrap;
            m_app = wrap && (sb_q.size() > 0);
            if (m_app) m_disp = sb_q.pop_front();
            if (ld) begin
                sb_q.delete();
                sb_q.push_back(din);
            end
            if (m_cnt == P - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % N;
            end else begin
                m_cnt++;
            end
        end
        #1;
        ea = 4'hF;
        if (m_cnt >= D) ea[m_idx] = 1'b0;
        if (bus1.applied === 1'b1) n_app++;
        chk("an_lz",      32'(bus1.an),         32'(ea));
        chk("an_nolz",    32'(bus0.an),         32'(ea));
        chk("frame_tick", 32'(bus1.frame_tick), 32'(m_ft));
        chk("applied",    32'(bus1.applied),    32'(m_app));
        chk("pending",    32'(bus1.pending),    32'(sb_q.size() > 0));
        chk("pending_nolz", 32'(bus0.pending),  32'(sb_q.size() > 0));
        if (was_reset) begin
            chk("rst_leds", 32'(bus1.leds), 32'h7F);
            chk("rst_an",   32'(bus1.an),   32'hF);
        end else if (m_cnt >= D) begin
            chk("leds_lz",   32'(bus1.leds), 32'(exp_leds(m_disp, m_idx, 1'b1)));
            chk("leds_nolz", 32'(bus0.leds), 32'(exp_leds(m_disp, m_idx, 1'b0)));
        end
    endtask

    task automatic go_to(input int ti, input int tc);
        for (int i = 0; i < 64; i++) begin
            if (m_idx == ti && m_cnt == tc) return;
            step();
        end
        chk("goto", 32'(m_idx * 16 + m_cnt), 32'(ti * 16 + tc));
    endtask

    task automatic load_val(input logic [15:0] v);
        ld  = 1'b1;
        din = v;
        step();
        ld  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ld    = 1'b0;
        din   = '0;
        step();
        step();
        reset = 1'b0;

        // Idle scan of a zero display
        repeat (70) step();

        // Single load mid-slot 1
        go_to(1, 3);
        n_app = 0;
        load_val(16'h0042);
        repeat (70) step();
        chk("t2_app_count", 32'(n_app), 32'd1);

        // Two loads in one frame: last wins, one applied pulse
        go_to(0, 4);
        n_app = 0;
        load_val(16'h1234);
        repeat (9) step();
        load_val(16'h5678);
        repeat (70) step();
        chk("t3_app_count", 32'(n_app), 32'd1);

        // Load on the wrap cycle with an older value still staged
        go_to(1, 0);
        load_val(16'h0099);
        go_to(3, 7);
        load_val(16'h0315);
        chk("t4_applied_now", 32'(bus1.applied), 32'd1);
        chk("t4_pending_now", 32'(bus1.pending), 32'd1);
        n_app = 0;
        repeat (31) step();
        chk("t4_pending_hold", 32'(bus1.pending), 32'd1);
        step();
        chk("t4_applied_next", 32'(bus1.applied), 32'd1);
        repeat (40) step();
        chk("t4_app_count", 32'(n_app), 32'd1);

        // Invalid BCD digit, with and without leading-zero blanking
        go_to(1, 0);
        load_val(16'h00A0);
        repeat (70) step();

        // Reset during slot 2 with a load pending
        go_to(1, 2);
        load_val(16'h2222);
        go_to(2, 4);
        reset = 1'b1;
        step();
        chk("t6_pending", 32'(bus1.pending), 32'd0);
        reset = 1'b0;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
